// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3).
// Converts the DIGITS*4-bit binary sum from the BCD adder back into packed
// BCD digits, one input bit per clock, and flags results that do not fit
// in DIGITS decimal digits. Valid/ready handshakes sit on both sides.
module bin2bcd_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGITS*4-1:0]   bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf
);

    localparam int BIN_W = DIGITS * 4;
    localparam int SCR_W = 2 * BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    // Scratch holds 2*DIGITS BCD digits; the upper half only ever matters
    // for the overflow flag, since 16^DIGITS < 100^DIGITS.
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_next;
    logic [BIN_W-1:0]   binreg;
    logic [CNT_W-1:0]   count;
    logic               last_iter;

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, run BIN_W shifts, wait for out_ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = SHIFT;
            SHIFT:   if (last_iter)            state_next = DONE;
            DONE:    if (out_ready)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Output logic: the input side is only open while idle and out of reset.
    always_comb begin
        in_ready = (state == IDLE) && !rst;
    end

    // Add-3 step: digits >= 5 become >= 8 so the following shift carries
    // into the next digit; a digit <= 9 plus 3 never exceeds 15.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 2 * DIGITS; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
        scratch_next = {scratch_adj[SCR_W-2:0], binreg[BIN_W-1]};
        last_iter    = (state == SHIFT) && (count == CNT_W'(1));
    end

    // Datapath: load on accept, iterate in SHIFT, capture the result on the
    // final iteration so bcd/ovf are valid in the same cycle as out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch   <= '0;
            binreg    <= '0;
            count     <= '0;
            bcd       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        binreg  <= bin;
                        scratch <= '0;
                        count   <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    binreg  <= {binreg[BIN_W-2:0], 1'b0};
                    count   <= count - CNT_W'(1);
                    if (last_iter) begin
                        bcd       <= scratch_next[BIN_W-1:0];
                        ovf       <= |scratch_next[SCR_W-1:BIN_W];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with a 4-digit and a
// 2-digit instance sharing clock and reset.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [15:0] bin, bcd;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
    logic [7:0]  bin2, bcd2;

    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;
    int          accepts4 = 0;
    int          accepts2 = 0;

    logic [16:0] exp4[$];
    logic [8:0]  exp2[$];
    int          deliver_cycles[$];

    bin2bcd_seq #(.DIGITS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    bin2bcd_seq #(.DIGITS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .bin       (bin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .bcd       (bcd2),
        .ovf       (ovf2)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Reference model: low decimal digits of v, packed as BCD.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] d;
        int unsigned t;
        d = '0;
        t = v;
        for (int i = 0; i < digits; i++) begin
            d[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return d;
    endfunction

    // Reference model: value does not fit in the given number of digits.
    function automatic logic ref_ovf(input int unsigned v, input int digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return v >= p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock: sample handshakes before the edge, then update the
    // scoreboards with what that edge did.
    task automatic step();
        logic        rst_s, acc4, acc2, del4, del2, ovf_s4, ovf_s2;
        logic [15:0] bin_s4, bcd_s4;
        logic [7:0]  bin_s2, bcd_s2;
        logic [31:0] rb;
        logic [16:0] e4;
        logic [8:0]  e2;
        #1;
        rst_s  = rst;
        acc4   = in_valid && in_ready;
        acc2   = in_valid2 && in_ready2;
        del4   = out_valid && out_ready;
        del2   = out_valid2 && out_ready2;
        bin_s4 = bin;
        bin_s2 = bin2;
        bcd_s4 = bcd;
        bcd_s2 = bcd2;
        ovf_s4 = ovf;
        ovf_s2 = ovf2;
        @(posedge clk);
        #1;
        cycle++;
        if (rst_s) begin
            exp4.delete();
            exp2.delete();
        end else begin
            if (del4) begin
                checkOutput("sb4_pending", 32'(exp4.size() > 0), 32'd1);
                if (exp4.size() > 0) begin
                    e4 = exp4.pop_front();
                    checkOutput("bcd4", 32'(bcd_s4), 32'(e4[15:0]));
                    checkOutput("ovf4", 32'(ovf_s4), 32'(e4[16]));
                end
                deliver_cycles.push_back(cycle);
            end
            if (del2) begin
                checkOutput("sb2_pending", 32'(exp2.size() > 0), 32'd1);
                if (exp2.size() > 0) begin
                    e2 = exp2.pop_front();
                    checkOutput("bcd2", 32'(bcd_s2), 32'(e2[7:0]));
                    checkOutput("ovf2", 32'(ovf_s2), 32'(e2[8]));
                end
            end
            if (acc4) begin
                rb = ref_bcd(32'(bin_s4), 4);
                exp4.push_back({ref_ovf(32'(bin_s4), 4), rb[15:0]});
                accepts4++;
            end
            if (acc2) begin
                rb = ref_bcd(32'(bin_s2), 2);
                exp2.push_back({ref_ovf(32'(bin_s2), 2), rb[7:0]});
                accepts2++;
            end
        end
    endtask

    // Wait until every accepted value has been delivered, bounded.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp4.size() + exp2.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_timeout", 32'(exp4.size() + exp2.size()), 32'd0);
    endtask

    // Convert one value on the 4-digit instance with out_ready held high.
    task automatic applyStimulus(input logic [15:0] v);
        int a;
        a = accepts4;
        in_valid  = 1'b1;
        bin       = v;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        checkOutput("accepted", 32'(accepts4 - a), 32'd1);
        drain(60);
    endtask

    initial begin
        int lat;
        int k;
        int base;
        int n;
        bit seen;
        logic [15:0] vals[3];

        rst = 1'b1;
        in_valid = 1'b0;  bin  = '0; out_ready  = 1'b0;
        in_valid2 = 1'b0; bin2 = '0; out_ready2 = 1'b0;
        step();
        step();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_bcd", 32'(bcd), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        step();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] basic conversion and latency");
        in_valid = 1'b1;
        bin      = 16'h04D2;
        step();
        in_valid = 1'b0;
        checkOutput("t1_in_ready_drop", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        checkOutput("t1_latency", 32'(lat), 32'd16);
        checkOutput("t1_bcd", 32'(bcd), 32'h1234);
        out_ready = 1'b1;
        step();
        drain(5);

        $display("[TB] boundary values");
        applyStimulus(16'h270F);
        checkOutput("t2_9999", 32'({ovf, bcd}), 32'h09999);
        applyStimulus(16'h2710);
        checkOutput("t2_10000", 32'({ovf, bcd}), 32'h10000);
        applyStimulus(16'hFFFF);
        checkOutput("t2_ffff", 32'({ovf, bcd}), 32'h15535);
        applyStimulus(16'h0000);
        checkOutput("t2_zero", 32'({ovf, bcd}), 32'h00000);

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin       = 16'h10E1;
        step();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        checkOutput("t3_latency", 32'(lat), 32'd16);
        base = accepts4;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            bin      = 16'($urandom);
            step();
            checkOutput("t3_hold_bcd", 32'(bcd), 32'h4321);
            checkOutput("t3_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t3_hold_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("t3_no_accept", 32'(accepts4 - base), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("t3_release_valid", 32'(out_valid), 32'd0);
        checkOutput("t3_release_ready", 32'(in_ready), 32'd1);
        checkOutput("t3_bcd_kept", 32'(bcd), 32'h4321);

        $display("[TB] mid-operation reset");
        in_valid = 1'b1;
        bin      = 16'd5678;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t4_abort_valid", 32'(out_valid), 32'd0);
        step();
        checkOutput("t4_ready_after", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        checkOutput("t4_no_result", 32'(seen), 32'd0);
        applyStimulus(16'd42);
        checkOutput("t4_after_42", 32'(bcd), 32'h0042);

        $display("[TB] back-to-back");
        deliver_cycles.delete();
        vals[0] = 16'd1; vals[1] = 16'd2; vals[2] = 16'd3;
        out_ready = 1'b1;
        base = accepts4;
        n = 0;
        k = 0;
        while ((k < 3 || exp4.size() != 0) && n < 200) begin
            in_valid = (k < 3);
            bin      = vals[(k < 3) ? k : 2];
            step();
            k = accepts4 - base;
            n++;
        end
        in_valid = 1'b0;
        checkOutput("t5_count", 32'(deliver_cycles.size()), 32'd3);
        if (deliver_cycles.size() == 3) begin
            checkOutput("t5_gap1", 32'(deliver_cycles[1] - deliver_cycles[0]), 32'd18);
            checkOutput("t5_gap2", 32'(deliver_cycles[2] - deliver_cycles[1]), 32'd18);
        end

        $display("[TB] random regression, 2 and 4 digits");
        base = accepts4;
        k    = accepts2;
        n    = 0;
        while (((accepts4 - base) < 1000 || (accepts2 - k) < 1000 ||
                exp4.size() != 0 || exp2.size() != 0) && n < 60000) begin
            in_valid   = (accepts4 - base) < 1000;
            in_valid2  = (accepts2 - k) < 1000;
            bin        = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            bin2       = 8'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            out_ready2 = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        checkOutput("rand_accepts4", 32'(accepts4 - base), 32'd1000);
        checkOutput("rand_accepts2", 32'(accepts2 - k), 32'd1000);
        checkOutput("rand_drained", 32'(exp4.size() + exp2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
